// File: rtl/lsu_data_port_if.sv
// Request/response handshake and data-port memory bus of the load/store unit.
// The slave modport is the LSU; the master modport is the execute stage plus memory side.
interface lsu_data_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  pLsu_iValid;
    logic                  pLsu_oReady;
    logic                  pLsu_iWr;
    logic [1:0]            pLsu_iSize;
    logic                  pLsu_iUnsigned;
    logic [ADDR_WIDTH-1:0] pLsu_iAddr;
    logic [DATA_WIDTH-1:0] pLsu_iData;
    logic                  pLsu_oValid;
    logic                  pLsu_iReady;
    logic [DATA_WIDTH-1:0] pLsu_oData;
    logic                  pLsu_oErr;
    logic                  pMemData_pRd_bEn;
    logic [ADDR_WIDTH-1:0] pMemData_pRd_bAddr;
    logic [DATA_WIDTH-1:0] pMemData_pRd_bData;
    logic                  pMemData_pWr_bEn;
    logic [ADDR_WIDTH-1:0] pMemData_pWr_bAddr;
    logic [DATA_WIDTH-1:0] pMemData_pWr_bData;
    logic                  pMemData_pWr_bMask_0;
    logic                  pMemData_pWr_bMask_1;
    logic                  pMemData_pWr_bMask_2;
    logic                  pMemData_pWr_bMask_3;

    modport slave (
        input  pLsu_iValid, pLsu_iWr, pLsu_iSize, pLsu_iUnsigned, pLsu_iAddr, pLsu_iData,
        input  pLsu_iReady, pMemData_pRd_bData,
        output pLsu_oReady, pLsu_oValid, pLsu_oData, pLsu_oErr,
        output pMemData_pRd_bEn, pMemData_pRd_bAddr,
        output pMemData_pWr_bEn, pMemData_pWr_bAddr, pMemData_pWr_bData,
        output pMemData_pWr_bMask_0, pMemData_pWr_bMask_1, pMemData_pWr_bMask_2, pMemData_pWr_bMask_3
    );

    modport master (
        output pLsu_iValid, pLsu_iWr, pLsu_iSize, pLsu_iUnsigned, pLsu_iAddr, pLsu_iData,
        output pLsu_iReady, pMemData_pRd_bData,
        input  pLsu_oReady, pLsu_oValid, pLsu_oData, pLsu_oErr,
        input  pMemData_pRd_bEn, pMemData_pRd_bAddr,
        input  pMemData_pWr_bEn, pMemData_pWr_bAddr, pMemData_pWr_bData,
        input  pMemData_pWr_bMask_0, pMemData_pWr_bMask_1, pMemData_pWr_bMask_2, pMemData_pWr_bMask_3
    );
endinterface

// File: rtl/lsu_data_port.sv
// Load/store unit: accepts one request, drives the data port for one cycle,
// extends load data and returns a registered response.
module lsu_data_port #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR  = 32'hFFFF_FFFC
) (
    input  logic             clock,
    input  logic             reset_n,
    lsu_data_port_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_wr;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic                  r_rd_en;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [3:0]            r_mask;
    logic [DATA_WIDTH-1:0] r_o_data;
    logic                  r_o_err;
    logic                  w_accept;
    logic                  w_illegal;

    function automatic logic f_illegal(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return lo[0];
            2'd2:    return (lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    // Mask is ordered {m0,m1,m2,m3}
    function automatic logic [3:0] f_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            2'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_store_data(input logic [DATA_WIDTH-1:0] d,
                                                           input logic [1:0] size);
        case (size)
            2'd0:    return {{(DATA_WIDTH-8){1'b0}}, d[7:0]};
            2'd1:    return {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_extend(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [1:0] size,
                                                       input logic uns);
        case (size)
            2'd0:    return {{(DATA_WIDTH-8){d[7] & ~uns}}, d[7:0]};
            2'd1:    return {{(DATA_WIDTH-16){d[15] & ~uns}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign w_accept  = bus.pLsu_iValid & (r_state == S_IDLE);
    assign w_illegal = f_illegal(bus.pLsu_iSize, bus.pLsu_iAddr[1:0]);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.pLsu_iValid) begin
                    w_next = w_illegal ? S_RESP : S_ACCESS;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ACCESS: w_next = S_RESP;
            S_RESP: begin
                if (bus.pLsu_iReady) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_RESP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture, one-cycle memory drive and response capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_rd_addr  <= IDLE_ADDR;
            r_wr_addr  <= IDLE_ADDR;
            r_wr_data  <= {DATA_WIDTH{1'b0}};
            r_mask     <= 4'b0000;
            r_o_data   <= {DATA_WIDTH{1'b0}};
            r_o_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wr       <= bus.pLsu_iWr;
                        r_size     <= bus.pLsu_iSize;
                        r_unsigned <= bus.pLsu_iUnsigned;
                        r_o_data   <= {DATA_WIDTH{1'b0}};
                        r_o_err    <= w_illegal;
                        if (!w_illegal && bus.pLsu_iWr) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= bus.pLsu_iAddr;
                            r_wr_data <= f_store_data(bus.pLsu_iData, bus.pLsu_iSize);
                            r_mask    <= f_mask(bus.pLsu_iSize);
                        end else if (!w_illegal) begin
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= bus.pLsu_iAddr;
                        end
                    end
                end
                S_ACCESS: begin
                    // Parking the buses on IDLE_ADDR gives back-to-back accesses an address edge
                    r_rd_en   <= 1'b0;
                    r_wr_en   <= 1'b0;
                    r_rd_addr <= IDLE_ADDR;
                    r_wr_addr <= IDLE_ADDR;
                    r_wr_data <= {DATA_WIDTH{1'b0}};
                    r_mask    <= 4'b0000;
                    r_o_err   <= 1'b0;
                    r_o_data  <= r_wr ? {DATA_WIDTH{1'b0}}
                                      : f_extend(bus.pMemData_pRd_bData, r_size, r_unsigned);
                end
                S_RESP: begin
                    r_o_data <= r_o_data;
                    r_o_err  <= r_o_err;
                end
                default: begin
                    r_rd_en <= 1'b0;
                    r_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pLsu_oReady          = (r_state == S_IDLE);
    assign bus.pLsu_oValid          = (r_state == S_RESP);
    assign bus.pLsu_oData           = r_o_data;
    assign bus.pLsu_oErr            = r_o_err;
    assign bus.pMemData_pRd_bEn     = r_rd_en;
    assign bus.pMemData_pRd_bAddr   = r_rd_addr;
    assign bus.pMemData_pWr_bEn     = r_wr_en;
    assign bus.pMemData_pWr_bAddr   = r_wr_addr;
    assign bus.pMemData_pWr_bData   = r_wr_data;
    assign bus.pMemData_pWr_bMask_0 = r_mask[3];
    assign bus.pMemData_pWr_bMask_1 = r_mask[2];
    assign bus.pMemData_pWr_bMask_2 = r_mask[1];
    assign bus.pMemData_pWr_bMask_3 = r_mask[0];

endmodule
